// File: rtl/enc_pkg.sv
// Shared types and constants for the latched priority encoder.
// Optional feature: ENC_ROUND_ROBIN_EN enables the rotating-priority search.
package enc_pkg;

    // Two-state handshake: waiting for a request, or holding a granted code
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Code for each request line; the code doubles as the line's position
    // in the B[3] -> B[0] search order, so pointer arithmetic is just +1.
    localparam logic [1:0] CODE_B3 = 2'b00;
    localparam logic [1:0] CODE_B2 = 2'b01;
    localparam logic [1:0] CODE_B1 = 2'b10;
    localparam logic [1:0] CODE_B0 = 2'b11;

    // Search position that follows a captured code (wraps B[0] -> B[3])
    function automatic logic [1:0] next_start(input logic [1:0] code);
        return code + 2'd1;
    endfunction

endpackage

// File: rtl/pri_pick.sv
// Combinational picker: finds the first set request line starting from a
// given search position and reports the winner code, any and multi.
module pri_pick
    import enc_pkg::*;
(
    input  logic [3:0] b,
    input  logic [1:0] start,
    output logic [1:0] code,
    output logic       any,
    output logic       multi
);

    // Request line that sits at a given search position
    function automatic logic line_at(input logic [3:0] req, input logic [1:0] pos);
        logic hit;
        case (pos)
            CODE_B3: hit = req[3];
            CODE_B2: hit = req[2];
            CODE_B1: hit = req[1];
            default: hit = req[0];
        endcase
        return hit;
    endfunction

    logic       found;
    logic [1:0] pos;
    logic [2:0] count;

    // Walk the four positions from the start pointer; first hit wins
    always_comb begin
        code  = start;
        found = 1'b0;
        pos   = start;
        for (int k = 0; k < 4; k++) begin
            pos = start + 2'(k);
            if (!found && line_at(b, pos)) begin
                code  = pos;
                found = 1'b1;
            end
        end
    end

    // Population count decides whether the capture saw competing requests
    always_comb begin
        count = {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]};
        any   = (b != 4'b0000);
        multi = (count > 3'd1);
    end

endmodule

// File: rtl/pri_enc_latch.sv
// Latched 4-to-2 priority encoder with a valid/ack hold handshake.
// Optional feature: define ENC_ROUND_ROBIN_EN for rotating priority;
// the default build uses fixed priority B[3] > B[2] > B[1] > B[0].
module pri_enc_latch
    import enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [3:0] B,
    input  logic       ack,
    output logic       A0,
    output logic       A1,
    output logic       valid,
    output logic       multi
);

    state_t     state;
    state_t     state_nxt;
    logic       capture;
    logic [1:0] code_q;
    logic       multi_q;
    logic [1:0] start;
    logic [1:0] pick_code;
    logic       pick_any;
    logic       pick_multi;

`ifdef ENC_ROUND_ROBIN_EN
    logic [1:0] ptr;

    // Rotation pointer moves past the winner only when a code is captured
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= CODE_B3;
        end else if (capture) begin
            ptr <= next_start(pick_code);
        end
    end

    assign start = ptr;
`else
    assign start = CODE_B3;
`endif

    pri_pick u_pick (
        .b     (B),
        .start (start),
        .code  (pick_code),
        .any   (pick_any),
        .multi (pick_multi)
    );

    // Next-state logic: capture from IDLE, release on ack or abort on E
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!E && pick_any) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (E || ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Code and multi flags load on capture and otherwise hold their value
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= 2'b00;
            multi_q <= 1'b0;
        end else if (capture) begin
            code_q  <= pick_code;
            multi_q <= pick_multi;
        end
    end

    assign valid = (state == HOLD);
    assign A1    = code_q[1];
    assign A0    = code_q[0];
    assign multi = multi_q;

endmodule

// File: tb/tb_pri_enc_latch.sv
// Self-checking bench for pri_enc_latch: a vector table plus a
// back-to-back grant sequence, checked through an expected-value queue.
module tb_pri_enc_latch;

    typedef struct packed {
        logic       v;
        logic [1:0] c;
        logic       m;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       e;
        logic [3:0] b;
        logic       ack;
        logic       ev;
        logic [1:0] ec;
        logic [1:0] ec_rr;
        logic       em;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       E;
    logic [3:0] B;
    logic       ack;
    logic       A0;
    logic       A1;
    logic       valid;
    logic       multi;

    exp_t sb[$];
    int   asserts  = 0;
    int   failures = 0;
    vec_t vecs[19];

    pri_enc_latch dut (
        .clk   (clk),
        .rst   (rst),
        .E     (E),
        .B     (B),
        .ack   (ack),
        .A0    (A0),
        .A1    (A1),
        .valid (valid),
        .multi (multi)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs on the falling edge and queue the expectation
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] b,
                                 input logic a, input exp_t ex);
        @(negedge clk);
        rst = r;
        E   = e;
        B   = b;
        ack = a;
        sb.push_back(ex);
    endtask

    // After the rising edge, pop the oldest expectation and compare
    task automatic checkOutput(input string name);
        exp_t ex;
        exp_t act;
        @(posedge clk);
        #1;
        asserts++;
        act = '{v: valid, c: {A1, A0}, m: multi};
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, got valid=%0b code=%02b multi=%0b",
                     name, act.v, act.c, act.m);
        end else begin
            ex = sb.pop_front();
            if (act !== ex) begin
                failures++;
                $display("[TB] FAIL %s: got valid=%0b code=%02b multi=%0b, want valid=%0b code=%02b multi=%0b",
                         name, act.v, act.c, act.m, ex.v, ex.c, ex.m);
            end
        end
    endtask

    initial begin
        exp_t ex;
        logic [1:0] want;
        int grant;

        rst = 1'b1;
        E   = 1'b0;
        B   = 4'b0000;
        ack = 1'b0;

        //          rst   e     b        ack   ev    ec     ec_rr  em
        vecs[0]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'b0101, 1'b0, 1'b1, 2'b01, 2'b11, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b01, 2'b11, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b01, 2'b11, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2'b01, 2'b11, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0};

        // Table vectors: reset, capture/hold/ack, multi, E abort, reset mid-HOLD
        for (int i = 0; i < 19; i++) begin
`ifdef ENC_ROUND_ROBIN_EN
            ex = '{v: vecs[i].ev, c: vecs[i].ec_rr, m: vecs[i].em};
`else
            ex = '{v: vecs[i].ev, c: vecs[i].ec, m: vecs[i].em};
`endif
            applyStimulus(vecs[i].rst, vecs[i].e, vecs[i].b, vecs[i].ack, ex);
            checkOutput($sformatf("vec%0d", i));
        end

        // Back-to-back grants with B=1111 held and ack asserted throughout
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, '{v: 1'b0, c: 2'b00, m: 1'b0});
        checkOutput("rr_reset");
        grant = 0;
        want  = 2'b00;
        for (int k = 0; k < 10; k++) begin
            if ((k % 2) == 0) begin
`ifdef ENC_ROUND_ROBIN_EN
                want = 2'(grant);
`else
                want = 2'b00;
`endif
                grant++;
                applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1, '{v: 1'b1, c: want, m: 1'b1});
            end else begin
                applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1, '{v: 1'b0, c: want, m: 1'b1});
            end
            checkOutput($sformatf("grant_seq%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
